// File: rtl/mem_fifo_arb.sv
// Two-requester round-robin front end for an external push-enabled shift pipeline.
// It tracks each in-flight entry's valid and source bits, and drains stale entries after an idle spell.
module mem_fifo_arb #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 2,
  parameter int IDLE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] fifo_in,
  output logic             fifo_wr,
  output logic             fifo_rst,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DRAIN} state_t;

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_LIMIT - 1);

  state_t           state_q, state_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] src_q, src_d;
  logic             pop_q, pop_d;
  logic [7:0]       idle_q, idle_d;
  logic             last_q, last_d;

  logic             gnt0_int, gnt1_int, wr_int, rst_int;
  logic             push_vld, push_src, win;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d  = state_q;
    vld_d    = vld_q;
    src_d    = src_q;
    idle_d   = idle_q;
    last_d   = last_q;
    gnt0_int = 1'b0;
    gnt1_int = 1'b0;
    wr_int   = 1'b0;
    rst_int  = 1'b0;
    fifo_in  = '0;
    push_vld = 1'b0;
    push_src = 1'b0;
    // On a tie the requester that did not win last time takes the grant.
    win      = (req0 & req1) ? ~last_q : req1;

    unique case (state_q)
      S_CLEAR: begin
        rst_int = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (req0 | req1) begin
          wr_int   = 1'b1;
          gnt0_int = ~win;
          gnt1_int = win;
          fifo_in  = win ? data1 : data0;
          push_vld = 1'b1;
          push_src = win;
          last_d   = win;
          idle_d   = '0;
        end else if (vld_q == '0) begin
          idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
          state_d = S_DRAIN;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      S_DRAIN: wr_int = 1'b1;
      default: state_d = S_CLEAR;
    endcase

    if (wr_int) begin
      vld_d[0] = push_vld;
      src_d[0] = push_src;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        src_d[i] = src_q[i-1];
      end
    end

    // Drain ends as soon as the shift about to happen leaves no real entries behind.
    if (state_q == S_DRAIN && vld_d == '0) state_d = S_RUN;

    pop_d = wr_int;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_CLEAR;
      vld_q   <= '0;
      src_q   <= '0;
      pop_q   <= 1'b0;
      idle_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      src_q   <= src_d;
      pop_q   <= pop_d;
      idle_q  <= idle_d;
      last_q  <= last_d;
    end
  end

  assign gnt0      = rst_n & gnt0_int;
  assign gnt1      = rst_n & gnt1_int;
  assign fifo_wr   = rst_n & wr_int;
  assign fifo_rst  = ~rst_n | rst_int;
  assign out_valid = rst_n & pop_q & vld_q[DEPTH-1];
  assign out_src   = src_q[DEPTH-1];
  assign out_data  = fifo_out;

endmodule

// File: tb/tb_mem_fifo_arb.sv
// Bench for mem_fifo_arb: directed vector table, corner sequences, then random traffic
// against a queue-based reference model; also hosts the external shift pipeline.
module tb_mem_fifo_arb;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 2;
  localparam int IDLE_LIMIT = 4;

  localparam int M_CLEAR = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic             clk = 1'b0;
  logic             rst_n, req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, fifo_wr, fifo_rst, out_valid, out_src;
  logic [WIDTH-1:0] fifo_in, fifo_out, out_data;

  always #5 clk = ~clk;

  mem_fifo_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_LIMIT(IDLE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .fifo_in(fifo_in), .fifo_wr(fifo_wr), .fifo_rst(fifo_rst),
    .fifo_out(fifo_out), .out_valid(out_valid), .out_data(out_data), .out_src(out_src)
  );

  // External pipeline the arbiter controls.
  logic [WIDTH-1:0] pipe_q [DEPTH];
  always @(posedge clk) begin
    if (fifo_rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (fifo_wr) begin
      pipe_q[0] <= fifo_in;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign fifo_out = pipe_q[DEPTH-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: in-flight entries as a fixed-length queue, newest at the front.
  typedef struct packed {logic v; logic s; logic [WIDTH-1:0] d;} slot_t;
  slot_t m_pipe[$];
  int    m_mode = M_CLEAR;
  int    m_idle = 0;
  bit    m_last = 1'b1;
  bit    m_pop  = 1'b0;

  // Expected values and DUT samples of the most recent cycle.
  logic             e_g0, e_g1, e_wr, e_rst, e_ov, e_os;
  logic [WIDTH-1:0] e_in, e_od;
  logic             s_g0, s_g1, s_wr, s_rst, s_ov, s_os;
  logic [WIDTH-1:0] s_in, s_od;

  function automatic int live_count();
    int n = 0;
    foreach (m_pipe[i]) if (m_pipe[i].v) n++;
    return n;
  endfunction

  task automatic cycle(input logic r, input logic q0, input logic q1,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    slot_t push;
    logic  win;
    slot_t tail;
    int    live_before;
    rst_n = r; req0 = q0; req1 = q1; data0 = d0; data1 = d1;

    e_g0 = 0; e_g1 = 0; e_wr = 0; e_rst = 0; e_in = '0; push = '0; win = 0;
    if (!r || m_mode == M_CLEAR) begin
      e_rst = 1;
    end else if (m_mode == M_RUN) begin
      if (q0 || q1) begin
        win  = (q0 && q1) ? !m_last : q1;
        e_g0 = !win;
        e_g1 = win;
        e_wr = 1;
        e_in = win ? d1 : d0;
        push = '{v: 1'b1, s: win, d: e_in};
      end
    end else begin
      e_wr = 1;
    end
    tail = m_pipe[DEPTH-1];
    e_ov = r && m_pop && tail.v;
    e_od = tail.d;
    e_os = tail.s;

    @(negedge clk);
    s_g0 = gnt0; s_g1 = gnt1; s_wr = fifo_wr; s_rst = fifo_rst;
    s_ov = out_valid; s_od = out_data; s_os = out_src; s_in = fifo_in;
    check($sformatf("c%0d model gnt0", cyc), s_g0, e_g0);
    check($sformatf("c%0d model gnt1", cyc), s_g1, e_g1);
    check($sformatf("c%0d model fifo_wr", cyc), s_wr, e_wr);
    check($sformatf("c%0d model fifo_rst", cyc), s_rst, e_rst);
    check($sformatf("c%0d model out_valid", cyc), s_ov, e_ov);
    if (e_wr) check($sformatf("c%0d model fifo_in", cyc), s_in, e_in);
    if (e_ov) begin
      check($sformatf("c%0d model out_data", cyc), s_od, e_od);
      check($sformatf("c%0d model out_src", cyc), s_os, e_os);
    end

    live_before = live_count();
    if (!r) begin
      m_mode = M_CLEAR; m_idle = 0; m_last = 1; m_pop = 0;
      foreach (m_pipe[i]) m_pipe[i] = '0;
    end else begin
      m_pop = e_wr;
      if (e_wr) begin
        m_pipe.push_front(push);
        void'(m_pipe.pop_back());
      end
      case (m_mode)
        M_CLEAR: m_mode = M_RUN;
        M_RUN: begin
          if (e_g0 || e_g1) begin
            m_last = win; m_idle = 0;
          end else if (live_before == 0) begin
            m_idle = 0;
          end else if (m_idle + 1 == IDLE_LIMIT) begin
            m_mode = M_DRAIN; m_idle = 0;
          end else begin
            m_idle++;
          end
        end
        default: if (live_count() == 0) m_mode = M_RUN;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, q0, q1; logic [WIDTH-1:0] d0, d1;
    logic g0, g1, wr, rst, ov; logic [WIDTH-1:0] od; logic os;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit               p0, p1;
    logic [WIDTH-1:0] dd0, dd1;
    int               rate;

    for (int i = 0; i < DEPTH; i++) m_pipe.push_back('0);
    rst_n = 0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    @(posedge clk);
    #1;

    //              r  q0 q1 d0     d1     g0 g1 wr rst ov od     os
    vecs.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0}); // reset
    vecs.push_back('{0, 1, 1, 8'hA0, 8'hB0, 0, 0, 0, 1, 0, 8'h00, 0}); // requests ignored in reset
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0}); // CLEAR
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0}); // RUN idle
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 1, 1, 8'hA0, 8'hB0, 1, 0, 1, 0, 0, 8'h00, 0}); // tie: req0 first
    vecs.push_back('{1, 1, 1, 8'hA0, 8'hB0, 0, 1, 1, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 1, 1, 8'hA0, 8'hB0, 1, 0, 1, 0, 1, 8'hA0, 0});
    vecs.push_back('{1, 1, 1, 8'hA0, 8'hB0, 0, 1, 1, 0, 1, 8'hB0, 1});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'hA0, 0}); // idle 1
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0}); // idle 2
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0}); // idle 3
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0}); // idle 4
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0}); // DRAIN 1
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'hB0, 1}); // DRAIN 2
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0}); // back in RUN
    vecs.push_back('{1, 1, 0, 8'h11, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0}); // req0 stream
    vecs.push_back('{1, 1, 0, 8'h22, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 1, 0, 8'h33, 8'h00, 1, 0, 1, 0, 1, 8'h11, 0});
    vecs.push_back('{1, 1, 0, 8'h44, 8'h00, 1, 0, 1, 0, 1, 8'h22, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h33, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 1, 0, 8'h77, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0}); // req0 held in DRAIN
    vecs.push_back('{1, 1, 0, 8'h77, 8'h00, 0, 0, 1, 0, 1, 8'h44, 0});
    vecs.push_back('{1, 1, 0, 8'h77, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0}); // granted first RUN cycle
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h77, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].q0, vecs[i].q1, vecs[i].d0, vecs[i].d1);
      check($sformatf("vec%0d gnt0", i), s_g0, vecs[i].g0);
      check($sformatf("vec%0d gnt1", i), s_g1, vecs[i].g1);
      check($sformatf("vec%0d fifo_wr", i), s_wr, vecs[i].wr);
      check($sformatf("vec%0d fifo_rst", i), s_rst, vecs[i].rst);
      check($sformatf("vec%0d out_valid", i), s_ov, vecs[i].ov);
      if (vecs[i].ov) begin
        check($sformatf("vec%0d out_data", i), s_od, vecs[i].od);
        check($sformatf("vec%0d out_src", i), s_os, vecs[i].os);
      end
    end

    // Single push by req1, then idle until the drain presents it.
    cycle(1, 0, 1, 8'h00, 8'h5A);
    check("r1push gnt1", s_g1, 1);
    check("r1push fifo_in", s_in, 8'h5A);
    for (int k = 0; k < IDLE_LIMIT; k++) begin
      cycle(1, 0, 0, 8'h00, 8'h00);
      check($sformatf("r1idle%0d fifo_wr", k), s_wr, 0);
      check($sformatf("r1idle%0d out_valid", k), s_ov, 0);
    end
    cycle(1, 0, 0, 8'h00, 8'h00);
    check("drain1 fifo_wr", s_wr, 1);
    check("drain1 fifo_in", s_in, 8'h00);
    check("drain1 out_valid", s_ov, 0);
    cycle(1, 0, 0, 8'h00, 8'h00);
    check("drain2 out_valid", s_ov, 1);
    check("drain2 out_data", s_od, 8'h5A);
    check("drain2 out_src", s_os, 1);
    cycle(1, 0, 0, 8'h00, 8'h00);
    check("post-drain fifo_wr", s_wr, 0);

    // Reset with both stages occupied: those entries must never be presented.
    cycle(1, 1, 0, 8'hC1, 8'h00);
    cycle(1, 1, 0, 8'hC2, 8'h00);
    cycle(0, 1, 0, 8'hC3, 8'h00);
    check("midrst out_valid", s_ov, 0);
    check("midrst fifo_rst", s_rst, 1);
    check("midrst gnt0", s_g0, 0);
    cycle(1, 1, 0, 8'hC3, 8'h00);
    check("midrst clear fifo_rst", s_rst, 1);
    check("midrst clear gnt0", s_g0, 0);
    cycle(1, 1, 0, 8'hC3, 8'h00);
    check("midrst run gnt0", s_g0, 1);
    check("midrst run fifo_rst", s_rst, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 8'h00, 8'h00);
      check($sformatf("midrst after%0d out_valid", k), s_ov, 0);
    end

    // Random traffic; each request is held with its data until granted.
    p0 = 0; p1 = 0; dd0 = '0; dd1 = '0; rate = 2;
    for (int n = 0; n < 4000; n++) begin
      logic r;
      if (n % 200 == 0) rate = $urandom_range(1, 8);
      if (!p0 && $urandom_range(0, rate) == 0) begin p0 = 1; dd0 = WIDTH'($urandom); end
      if (!p1 && $urandom_range(0, rate) == 0) begin p1 = 1; dd1 = WIDTH'($urandom); end
      r = ($urandom_range(0, 249) != 0);
      cycle(r, p0, p1, dd0, dd1);
      if (e_g0) p0 = 0;
      if (e_g1) p1 = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
